// File: rtl/tagger_sequencer.sv
// Run controller for the event tagger: sequences timer/capture controls and forwards records to the FIFO.
// Optional lost-record marker insertion is enabled by defining TAGGER_LOST_MARKER_EN.
module tagger_sequencer #(
  parameter int LOST_W = 16,
  parameter int WRAP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic [WRAP_W-1:0] run_wraps,
  output logic              reset_counter,
  output logic              counter_operate,
  output logic              capture_operate,
  input  logic              rec_ready,
  input  logic [46:0]       rec_data,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [46:0]       fifo_wr_data,
  output logic              running,
  output logic [LOST_W-1:0] lost_total,
  output logic [WRAP_W-1:0] wraps_seen
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              start_acc;
  logic              stop_acc;
  logic              auto_stop;
  logic              wrap_rec;
  logic              wrap_inc;
  logic              loss;
  logic              origin_seen;
  logic              origin_nxt;
  logic [LOST_W-1:0] lost_nxt;
  logic [WRAP_W-1:0] wraps_nxt;
  logic              wr_en_nxt;
  logic [46:0]       wr_data_nxt;

  function automatic logic [LOST_W-1:0] sat_inc_lost(input logic [LOST_W-1:0] v);
    return (&v) ? v : v + LOST_W'(1);
  endfunction

  function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
    return (&v) ? v : v + WRAP_W'(1);
  endfunction

  always_comb begin
    start_acc = (state == IDLE) && cmd_start && !cmd_stop;
    wrap_rec  = rec_ready && rec_data[46];
    // the first wrap record of a run marks the timer origin and is not counted
    wrap_inc  = wrap_rec && origin_seen && !(&wraps_seen);
    auto_stop = wrap_inc && (run_wraps != '0) &&
                (sat_inc_wrap(wraps_seen) == run_wraps);
    stop_acc  = (state == RUN) && (cmd_stop || auto_stop);
    loss      = rec_ready && fifo_full;

    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = RUN;
      RUN:     if (stop_acc) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lost_nxt   = lost_total;
    wraps_nxt  = wraps_seen;
    origin_nxt = origin_seen;
    if (start_acc) begin
      lost_nxt   = '0;
      wraps_nxt  = '0;
      origin_nxt = 1'b0;
    end else begin
      if (wrap_inc) wraps_nxt = sat_inc_wrap(wraps_seen);
      if (wrap_rec) origin_nxt = 1'b1;
    end
    if (loss) lost_nxt = sat_inc_lost(lost_nxt);
  end

`ifdef TAGGER_LOST_MARKER_EN
  logic [LOST_W-1:0] pend;
  logic [LOST_W-1:0] pend_nxt;
  logic              marker;

  always_comb begin
    // markers only fill otherwise idle, non-full cycles; tagger records always win
    marker   = !rec_ready && !fifo_full && (pend != '0) && !start_acc;
    pend_nxt = (start_acc || marker) ? '0 : pend;
    if (loss) pend_nxt = sat_inc_lost(pend_nxt);

    wr_en_nxt   = rec_ready && !fifo_full;
    wr_data_nxt = rec_data;
    if (marker) begin
      wr_en_nxt                   = 1'b1;
      wr_data_nxt                 = '0;
      wr_data_nxt[44]             = 1'b1;
      wr_data_nxt[LOST_W-1:0]     = pend;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pend <= '0;
    else          pend <= pend_nxt;
  end
`else
  always_comb begin
    wr_en_nxt   = rec_ready && !fifo_full;
    wr_data_nxt = rec_data;
  end
`endif

  // control outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      reset_counter   <= 1'b1;
      counter_operate <= 1'b0;
      capture_operate <= 1'b0;
      running         <= 1'b0;
      origin_seen     <= 1'b0;
      lost_total      <= '0;
      wraps_seen      <= '0;
      fifo_wr_en      <= 1'b0;
      fifo_wr_data    <= '0;
    end else begin
      state           <= state_nxt;
      reset_counter   <= (state_nxt == IDLE);
      counter_operate <= (state_nxt == RUN);
      capture_operate <= (state_nxt == RUN);
      running         <= (state_nxt == RUN);
      origin_seen     <= origin_nxt;
      lost_total      <= lost_nxt;
      wraps_seen      <= wraps_nxt;
      fifo_wr_en      <= wr_en_nxt;
      if (wr_en_nxt) fifo_wr_data <= wr_data_nxt;
    end
  end

endmodule
